// File: rtl/display_pkg.sv
// display_pkg: shared constants for the seven-segment display driver.
// Segment patterns are active-high with bit 0 = segment a through bit 6 = g.
package display_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;

    localparam logic [6:0] SEG_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,   // 0 1 2 3
        7'h66, 7'h6D, 7'h7D, 7'h07,   // 4 5 6 7
        7'h7F, 7'h6F, 7'h77, 7'h7C,   // 8 9 A b
        7'h39, 7'h5E, 7'h79, 7'h71    // C d E F
    };

    // Width of an index over n entries; never narrower than one bit.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/display_driver_if.sv
// display_driver_if: controller-side digit bus and board-side pin bundle.
// The blink_in field exists only when DISPLAY_BLINK_EN is defined.
interface display_driver_if #(
    parameter int DIGITS = 8
);
    logic                  load;
    logic [4*DIGITS-1:0]   digits_in;
    logic [DIGITS-1:0]     dp_in;
    logic [DIGITS-1:0]     blank_in;
`ifdef DISPLAY_BLINK_EN
    logic [DIGITS-1:0]     blink_in;
`endif
    logic [DIGITS-1:0]     an;
    logic [6:0]            seg;
    logic                  dp;
    logic                  frame_done;

    modport master (
`ifdef DISPLAY_BLINK_EN
        output blink_in,
`endif
        output load, digits_in, dp_in, blank_in,
        input  an, seg, dp, frame_done
    );

    modport slave (
`ifdef DISPLAY_BLINK_EN
        input  blink_in,
`endif
        input  load, digits_in, dp_in, blank_in,
        output an, seg, dp, frame_done
    );
endinterface

// File: rtl/seg_decode.sv
// seg_decode: hex nibble to active-high a..g pattern (lowercase b and d).
module seg_decode
    import display_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] pat_o
);
    assign pat_o = SEG_TABLE[nib_i];
endmodule

// File: rtl/display_driver.sv
// display_driver: time-multiplexed common-anode seven-segment scanner.
// Digit data is double-buffered: load writes the shadow set, and the live set
// only changes at a frame boundary, so a frame never shows mixed data.
// Optional feature macro: DISPLAY_BLINK_EN (per-digit blink, BLINK_FRAMES).
module display_driver
    import display_pkg::*;
#(
    parameter int DIGITS       = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD        = 4
`ifdef DISPLAY_BLINK_EN
    ,
    parameter int BLINK_FRAMES = 64
`endif
) (
    input  logic            clk,
    input  logic            rst_n,
    display_driver_if.slave bus
);
    localparam int IDX_W = idx_width(DIGITS);
    localparam int DIV_W = idx_width(SCAN_DIV);

    logic [DIV_W-1:0]    div_q, div_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                pending_q, pending_d;
    logic [4*DIGITS-1:0] sh_digits_q, lv_digits_q;
    logic [DIGITS-1:0]   sh_dp_q, lv_dp_q, sh_blank_q, lv_blank_q;

    logic [DIGITS-1:0]   an_q, an_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic                fd_q, fd_d;

    logic                tick, boundary, in_guard, dark;
    logic [3:0]          cur_nib;
    logic [6:0]          cur_pat;

    assign tick     = (div_q == DIV_W'(SCAN_DIV - 1));
    assign boundary = tick && (idx_q == IDX_W'(DIGITS - 1));
    assign in_guard = (div_q < DIV_W'(GUARD));
    assign cur_nib  = lv_digits_q[{idx_q, 2'b00} +: 4];

    seg_decode u_dec (
        .nib_i (cur_nib),
        .pat_o (cur_pat)
    );

`ifdef DISPLAY_BLINK_EN
    localparam int BF_W = idx_width(BLINK_FRAMES);

    logic [DIGITS-1:0] sh_blink_q, lv_blink_q;
    logic [BF_W-1:0]   bcnt_q, bcnt_d;
    logic              bph_q, bph_d;

    // Blink phase flips after every BLINK_FRAMES frame boundaries.
    always_comb begin
        bcnt_d = bcnt_q;
        bph_d  = bph_q;
        if (boundary) begin
            if (bcnt_q == BF_W'(BLINK_FRAMES - 1)) begin
                bcnt_d = '0;
                bph_d  = ~bph_q;
            end else begin
                bcnt_d = bcnt_q + BF_W'(1);
            end
        end
    end

    // Blink shadow/live flags and frame counter state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_blink_q <= '0;
            lv_blink_q <= '0;
            bcnt_q     <= '0;
            bph_q      <= 1'b0;
        end else begin
            if (boundary && pending_q) lv_blink_q <= sh_blink_q;
            if (bus.load)              sh_blink_q <= bus.blink_in;
            bcnt_q <= bcnt_d;
            bph_q  <= bph_d;
        end
    end

    assign dark = lv_blank_q[idx_q] | (bph_q & lv_blink_q[idx_q]);
`else
    assign dark = lv_blank_q[idx_q];
`endif

    // Slot divider, slot index and pending flag; a load in the boundary
    // cycle re-arms pending so its data waits for the following boundary.
    always_comb begin
        div_d     = tick ? '0 : div_q + DIV_W'(1);
        idx_d     = idx_q;
        pending_d = pending_q;
        if (tick) begin
            idx_d = (idx_q == IDX_W'(DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        if (bus.load) begin
            pending_d = 1'b1;
        end else if (boundary) begin
            pending_d = 1'b0;
        end
    end

    // Pin values for the current slot; everything dark during the guard window.
    always_comb begin
        an_d  = '1;
        seg_d = SEG_OFF;
        dp_d  = 1'b1;
        fd_d  = boundary;
        if (!in_guard) begin
            an_d = ~(DIGITS'(1) << idx_q);
            if (!dark) begin
                seg_d = ~cur_pat;
                dp_d  = ~lv_dp_q[idx_q];
            end
        end
    end

    // Scan state and registered pin outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q     <= '0;
            idx_q     <= '0;
            pending_q <= 1'b0;
            an_q      <= '1;
            seg_q     <= SEG_OFF;
            dp_q      <= 1'b1;
            fd_q      <= 1'b0;
        end else begin
            div_q     <= div_d;
            idx_q     <= idx_d;
            pending_q <= pending_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            fd_q      <= fd_d;
        end
    end

    // Shadow captures on load; live copies shadow only at a pending boundary.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_digits_q <= '0;
            lv_digits_q <= '0;
            sh_dp_q     <= '0;
            lv_dp_q     <= '0;
            sh_blank_q  <= '1;
            lv_blank_q  <= '1;
        end else begin
            if (boundary && pending_q) begin
                lv_digits_q <= sh_digits_q;
                lv_dp_q     <= sh_dp_q;
                lv_blank_q  <= sh_blank_q;
            end
            if (bus.load) begin
                sh_digits_q <= bus.digits_in;
                sh_dp_q     <= bus.dp_in;
                sh_blank_q  <= bus.blank_in;
            end
        end
    end

    assign bus.an         = an_q;
    assign bus.seg        = seg_q;
    assign bus.dp         = dp_q;
    assign bus.frame_done = fd_q;

endmodule
